// File: rtl/acc_offload_tracker.sv
// acc_offload_tracker: tags core offloads with a free table slot and maps responses back to rd; ACC_OFFLOAD_TRACKER_RSP_SPILL_EN adds a 2-entry response spill.
// Request path is combinational and stalls while the table is full; the response path is combinational, or has 1 cycle of latency with the spill.
package acc_pkg;
  parameter int AccAddrWidth = 32;
endpackage

module acc_offload_tracker #(
  parameter int NumOutstanding = 4,
  parameter int AccAddrWidth   = acc_pkg::AccAddrWidth,
  parameter int DataWidth      = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  core_q_valid_i,
  output logic                                  core_q_ready_o,
  input  logic [AccAddrWidth-1:0]               core_q_addr_i,
  input  logic [31:0]                           core_q_data_op_i,
  input  logic [DataWidth-1:0]                  core_q_data_arga_i,
  input  logic [DataWidth-1:0]                  core_q_data_argb_i,
  input  logic [DataWidth-1:0]                  core_q_data_argc_i,
  input  logic [4:0]                            core_q_rd_i,
  output logic                                  core_p_valid_o,
  input  logic                                  core_p_ready_i,
  output logic [DataWidth-1:0]                  core_p_data_o,
  output logic [4:0]                            core_p_rd_o,
  output logic                                  core_p_error_o,
  output logic                                  acc_q_valid_o,
  input  logic                                  acc_q_ready_i,
  output logic [AccAddrWidth-1:0]               acc_q_addr_o,
  output logic [31:0]                           acc_q_data_op_o,
  output logic [DataWidth-1:0]                  acc_q_data_arga_o,
  output logic [DataWidth-1:0]                  acc_q_data_argb_o,
  output logic [DataWidth-1:0]                  acc_q_data_argc_o,
  output logic [4:0]                            acc_q_id_o,
  input  logic                                  acc_p_valid_i,
  output logic                                  acc_p_ready_o,
  input  logic [DataWidth-1:0]                  acc_p_data_i,
  input  logic [4:0]                            acc_p_id_i,
  output logic [$clog2(NumOutstanding+1)-1:0]   outstanding_o
);
  localparam int IdxW = $clog2(NumOutstanding);
  localparam int CntW = $clog2(NumOutstanding+1);

  logic [NumOutstanding-1:0] valid_q, valid_d;
  logic [4:0]                rd_q [NumOutstanding];
  logic [4:0]                rd_d [NumOutstanding];
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic            has_free;
  logic [IdxW-1:0] alloc_idx;
  logic            alloc_fire;
  logic            rsp_known;
  logic [4:0]      rsp_rd;
  logic            rsp_hs;
  logic            rel_fire;

  // Descending scan so the lowest free index wins; uses registered state only.
  always_comb begin
    has_free  = 1'b0;
    alloc_idx = '0;
    for (int i = NumOutstanding - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free  = 1'b1;
        alloc_idx = IdxW'(i);
      end
    end
  end

  // Out-of-range ids never match any slot, so they fall out as unknown.
  always_comb begin
    rsp_known = 1'b0;
    rsp_rd    = '0;
    for (int i = 0; i < NumOutstanding; i++) begin
      if (acc_p_id_i == 5'(i) && valid_q[i]) begin
        rsp_known = 1'b1;
        rsp_rd    = rd_q[i];
      end
    end
  end

  assign acc_q_valid_o     = core_q_valid_i & has_free;
  assign core_q_ready_o    = acc_q_ready_i & has_free;
  assign acc_q_addr_o      = core_q_addr_i;
  assign acc_q_data_op_o   = core_q_data_op_i;
  assign acc_q_data_arga_o = core_q_data_arga_i;
  assign acc_q_data_argb_o = core_q_data_argb_i;
  assign acc_q_data_argc_o = core_q_data_argc_i;
  assign acc_q_id_o        = 5'(alloc_idx);
  assign alloc_fire        = core_q_valid_i & acc_q_ready_i & has_free;
  assign rel_fire          = rsp_hs & rsp_known;
  assign outstanding_o     = cnt_q;

`ifdef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [4:0]           rd;
    logic                 err;
  } rsp_t;

  rsp_t       sp_q [2];
  rsp_t       sp_d [2];
  rsp_t       sp_head;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] sp_cnt_q, sp_cnt_d;
  logic       sp_pop;

  // Ready depends only on buffer occupancy, never on core_p_ready_i.
  assign acc_p_ready_o  = (sp_cnt_q != 2'd2);
  assign rsp_hs         = acc_p_valid_i & acc_p_ready_o;
  assign core_p_valid_o = (sp_cnt_q != 2'd0);
  assign sp_pop         = core_p_valid_o & core_p_ready_i;
  assign sp_head        = sp_q[rd_ptr_q];
  assign core_p_data_o  = sp_head.data;
  assign core_p_rd_o    = sp_head.rd;
  assign core_p_error_o = sp_head.err;

  always_comb begin
    sp_d     = sp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rsp_hs) begin
      sp_d[wr_ptr_q] = '{data: acc_p_data_i, rd: rsp_rd, err: ~rsp_known};
      wr_ptr_d       = ~wr_ptr_q;
    end
    if (sp_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    sp_cnt_d = sp_cnt_q + 2'(rsp_hs) - 2'(sp_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q[0]  <= '0;
      sp_q[1]  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sp_cnt_q <= '0;
    end else begin
      sp_q     <= sp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sp_cnt_q <= sp_cnt_d;
    end
  end
`else
  // Valid is masked in reset so a stale acc_p_valid_i cannot leak through.
  assign core_p_valid_o = acc_p_valid_i & ~rst_i;
  assign core_p_data_o  = acc_p_data_i;
  assign core_p_rd_o    = rsp_rd;
  assign core_p_error_o = ~rsp_known;
  assign acc_p_ready_o  = core_p_ready_i;
  assign rsp_hs         = acc_p_valid_i & core_p_ready_i;
`endif

  // Alloc and release never hit the same slot: alloc only picks a free one.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    for (int i = 0; i < NumOutstanding; i++) begin
      if (rel_fire && acc_p_id_i == 5'(i)) begin
        valid_d[i] = 1'b0;
      end
    end
    if (alloc_fire) begin
      valid_d[alloc_idx] = 1'b1;
      rd_d[alloc_idx]    = core_q_rd_i;
    end
    cnt_d = cnt_q + CntW'(alloc_fire) - CntW'(rel_fire);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NumOutstanding; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_acc_offload_tracker.sv
// Directed bench for acc_offload_tracker with a slot-table/response-queue reference model checked every cycle.
module tb_acc_offload_tracker;
  localparam int N  = 4;
  localparam int AW = acc_pkg::AccAddrWidth;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          core_q_valid_i, core_q_ready_o;
  logic [AW-1:0] core_q_addr_i;
  logic [31:0]   core_q_data_op_i;
  logic [DW-1:0] core_q_data_arga_i, core_q_data_argb_i, core_q_data_argc_i;
  logic [4:0]    core_q_rd_i;
  logic          core_p_valid_o, core_p_ready_i;
  logic [DW-1:0] core_p_data_o;
  logic [4:0]    core_p_rd_o;
  logic          core_p_error_o;
  logic          acc_q_valid_o, acc_q_ready_i;
  logic [AW-1:0] acc_q_addr_o;
  logic [31:0]   acc_q_data_op_o;
  logic [DW-1:0] acc_q_data_arga_o, acc_q_data_argb_o, acc_q_data_argc_o;
  logic [4:0]    acc_q_id_o;
  logic          acc_p_valid_i, acc_p_ready_o;
  logic [DW-1:0] acc_p_data_i;
  logic [4:0]    acc_p_id_i;
  logic [$clog2(N+1)-1:0] outstanding_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  acc_offload_tracker #(.NumOutstanding(N), .AccAddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_q_valid_i(core_q_valid_i), .core_q_ready_o(core_q_ready_o),
    .core_q_addr_i(core_q_addr_i), .core_q_data_op_i(core_q_data_op_i),
    .core_q_data_arga_i(core_q_data_arga_i), .core_q_data_argb_i(core_q_data_argb_i),
    .core_q_data_argc_i(core_q_data_argc_i), .core_q_rd_i(core_q_rd_i),
    .core_p_valid_o(core_p_valid_o), .core_p_ready_i(core_p_ready_i),
    .core_p_data_o(core_p_data_o), .core_p_rd_o(core_p_rd_o), .core_p_error_o(core_p_error_o),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_q_addr_o(acc_q_addr_o), .acc_q_data_op_o(acc_q_data_op_o),
    .acc_q_data_arga_o(acc_q_data_arga_o), .acc_q_data_argb_o(acc_q_data_argb_o),
    .acc_q_data_argc_o(acc_q_data_argc_o), .acc_q_id_o(acc_q_id_o),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
    .acc_p_data_i(acc_p_data_i), .acc_p_id_i(acc_p_id_i),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot table as plain arrays, spill as a response queue.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [4:0]    rd;
    logic          err;
  } rsp_t;

  bit         mv [N];
  logic [4:0] mr [N];
  rsp_t       pq [$];

  always @(negedge clk_i) begin
    int   idx;
    int   busy;
    bit   known;
    bit   rel;
    bit   alloc;
    bit   exp_pv;
    bit   exp_ar;
    logic [4:0] lrd;
    if (!done) begin
      if (rst_i) begin
        for (int i = 0; i < N; i++) begin
          mv[i] = 1'b0;
          mr[i] = '0;
        end
        pq.delete();
      end
      idx  = -1;
      busy = 0;
      for (int i = N - 1; i >= 0; i--) if (!mv[i]) idx = i;
      for (int i = 0; i < N; i++) busy += int'(mv[i]);
      known = 1'b0;
      lrd   = '0;
      if (int'(acc_p_id_i) < N) begin
        known = mv[acc_p_id_i];
        if (known) lrd = mr[acc_p_id_i];
      end

      chk("outstanding", 64'(outstanding_o), 64'(busy));
      chk("acc_q_valid", 64'(acc_q_valid_o), 64'(core_q_valid_i && idx >= 0));
      chk("core_q_ready", 64'(core_q_ready_o), 64'(acc_q_ready_i && idx >= 0));
      if (idx >= 0) chk("acc_q_id", 64'(acc_q_id_o), 64'(idx));
      if (core_q_valid_i && idx >= 0) begin
        chk("acc_q_addr", 64'(acc_q_addr_o), 64'(core_q_addr_i));
        chk("acc_q_op", 64'(acc_q_data_op_o), 64'(core_q_data_op_i));
        chk("acc_q_args", {acc_q_data_arga_o ^ acc_q_data_argc_o, acc_q_data_argb_o},
            {core_q_data_arga_i ^ core_q_data_argc_i, core_q_data_argb_i});
      end

`ifdef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
      exp_ar = (pq.size() < 2);
      exp_pv = (pq.size() > 0) && !rst_i;
      chk("acc_p_ready", 64'(acc_p_ready_o), 64'(exp_ar));
      chk("core_p_valid", 64'(core_p_valid_o), 64'(exp_pv));
      if (exp_pv) begin
        chk("core_p_data", 64'(core_p_data_o), 64'(pq[0].d));
        chk("core_p_rd", 64'(core_p_rd_o), 64'(pq[0].rd));
        chk("core_p_error", 64'(core_p_error_o), 64'(pq[0].err));
      end
      rel = acc_p_valid_i && exp_ar && known;
      if (!rst_i) begin
        if (exp_pv && core_p_ready_i) void'(pq.pop_front());
        if (acc_p_valid_i && exp_ar) pq.push_back('{d: acc_p_data_i, rd: lrd, err: !known});
      end
`else
      exp_pv = acc_p_valid_i && !rst_i;
      chk("acc_p_ready", 64'(acc_p_ready_o), 64'(core_p_ready_i));
      chk("core_p_valid", 64'(core_p_valid_o), 64'(exp_pv));
      if (exp_pv) begin
        chk("core_p_data", 64'(core_p_data_o), 64'(acc_p_data_i));
        chk("core_p_rd", 64'(core_p_rd_o), 64'(lrd));
        chk("core_p_error", 64'(core_p_error_o), 64'(!known));
      end
      rel = acc_p_valid_i && core_p_ready_i && known;
`endif
      alloc = core_q_valid_i && acc_q_ready_i && idx >= 0;
      if (!rst_i) begin
        if (rel) mv[acc_p_id_i] = 1'b0;
        if (alloc) begin
          mv[idx] = 1'b1;
          mr[idx] = core_q_rd_i;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic v, input logic [4:0] rd);
    core_q_valid_i     = v;
    core_q_rd_i        = rd;
    core_q_addr_i      = AW'(32'h1000 + 32'(rd));
    core_q_data_op_i   = 32'hA000_0000 | 32'(rd);
    core_q_data_arga_i = DW'(32'h11 * 32'(rd));
    core_q_data_argb_i = DW'(32'h22 * 32'(rd));
    core_q_data_argc_i = DW'(32'h33 * 32'(rd));
  endtask

  task automatic rsp(input logic v, input logic [4:0] id, input logic [DW-1:0] d, input logic rdy);
    acc_p_valid_i  = v;
    acc_p_id_i     = id;
    acc_p_data_i   = d;
    core_p_ready_i = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    acc_q_ready_i = 1'b0;
    req(1'b1, 5'd0);
    rsp(1'b1, 5'd0, 32'h0, 1'b1);
    #2;
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_core_p_valid", 64'(core_p_valid_o), 64'd0);
    chk("rst_acc_q_valid", 64'(acc_q_valid_o), 64'd1);
    tick(); tick();
    rst_i = 1'b0;
    req(1'b0, 5'd0);
    rsp(1'b0, 5'd0, 32'h0, 1'b1);
    acc_q_ready_i = 1'b1;
    tick();

    // Fill the table with rd 1..4.
    for (int k = 0; k < N; k++) begin
      req(1'b1, 5'(k + 1));
      #1 chk("fill_id", 64'(acc_q_id_o), 64'(k));
      tick();
    end
    req(1'b1, 5'd5);
    #1;
    chk("full_outstanding", 64'(outstanding_o), 64'd4);
    chk("full_core_q_ready", 64'(core_q_ready_o), 64'd0);
    chk("full_acc_q_valid", 64'(acc_q_valid_o), 64'd0);

    // Release slot 2 while full; its reuse shows up one cycle later.
    rsp(1'b1, 5'd2, 32'hDEADBEEF, 1'b1);
    #1;
`ifndef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
    chk("rsp2_rd", 64'(core_p_rd_o), 64'd3);
    chk("rsp2_err", 64'(core_p_error_o), 64'd0);
`endif
    chk("no_bypass_ready", 64'(core_q_ready_o), 64'd0);
    tick();
    rsp(1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("realloc_id", 64'(acc_q_id_o), 64'd2);
    chk("realloc_ready", 64'(core_q_ready_o), 64'd1);
    tick();
    req(1'b0, 5'd0);

    // Unknown id completes without touching the table.
    rsp(1'b1, 5'd7, 32'h1234, 1'b1);
    #1;
    chk("bad_id_ready", 64'(acc_p_ready_o), 64'd1);
`ifndef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
    chk("bad_id_err", 64'(core_p_error_o), 64'd1);
    chk("bad_id_rd", 64'(core_p_rd_o), 64'd0);
`endif
    tick();
    rsp(1'b0, 5'd0, 32'h0, 1'b1);
    #1 chk("bad_id_outstanding", 64'(outstanding_o), 64'd4);

    // Leave slots 0 and 2, then alloc slot 1 and release slot 0 together.
    rsp(1'b1, 5'd1, 32'h0000_0101, 1'b1);
    tick();
    rsp(1'b1, 5'd3, 32'h0000_0303, 1'b1);
    tick();
    req(1'b1, 5'd10);
    rsp(1'b1, 5'd0, 32'h0000_0A0A, 1'b1);
    #1;
    chk("swap_id", 64'(acc_q_id_o), 64'd1);
    chk("swap_pre_outstanding", 64'(outstanding_o), 64'd2);
`ifndef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
    chk("swap_rsp_rd", 64'(core_p_rd_o), 64'd1);
`endif
    tick();
    req(1'b0, 5'd0);
    rsp(1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("swap_outstanding", 64'(outstanding_o), 64'd2);
    chk("swap_free_id", 64'(acc_q_id_o), 64'd0);

    // Core stalls a response for three cycles.
    rsp(1'b1, 5'd1, 32'hCAFE0001, 1'b0);
    #1;
`ifdef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
    chk("spill_latency", 64'(core_p_valid_o), 64'd0);
`endif
    for (int c = 0; c < 3; c++) begin
`ifndef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
      chk("stall_valid", 64'(core_p_valid_o), 64'd1);
      chk("stall_data", 64'(core_p_data_o), 64'hCAFE0001);
      chk("stall_rd", 64'(core_p_rd_o), 64'd10);
      chk("stall_held", 64'(outstanding_o), 64'd2);
`endif
      tick();
    end
    core_p_ready_i = 1'b1;
    tick();
    rsp(1'b0, 5'd0, 32'h0, 1'b1);
    #1 chk("stall_released", 64'(outstanding_o), 64'd1);
    tick(); tick();

    // Reset with three in flight drops tracking.
    req(1'b1, 5'd11);
    tick();
    req(1'b1, 5'd12);
    tick();
    req(1'b0, 5'd0);
    #1 chk("pre_rst_outstanding", 64'(outstanding_o), 64'd3);
    rst_i = 1'b1;
    #1 chk("async_rst_outstanding", 64'(outstanding_o), 64'd0);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    rsp(1'b1, 5'd1, 32'h0000_0055, 1'b1);
    #1;
`ifndef ACC_OFFLOAD_TRACKER_RSP_SPILL_EN
    chk("post_rst_err", 64'(core_p_error_o), 64'd1);
    chk("post_rst_rd", 64'(core_p_rd_o), 64'd0);
`endif
    tick();
    rsp(1'b0, 5'd0, 32'h0, 1'b1);
    tick(); tick(); tick();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_offload_tracker.md
ACC_OFFLOAD_TRACKER -- requirements
Module: acc_offload_tracker

Interface
REQ-001 SHALL have parameter NumOutstanding, default 4, meaning max in-flight offloads (2..32).
REQ-002 SHALL have parameter AccAddrWidth, default acc_pkg::AccAddrWidth, meaning target accelerator address width.
REQ-003 SHALL have parameter DataWidth, default 32, meaning operand/result width.
REQ-004 SHALL have ports clk_i in 1 (the single clock) and rst_i in 1 (reset, asynchronous, active-high).
REQ-005 SHALL have core request ports: core_q_valid_i in 1; core_q_ready_o out 1; core_q_addr_i in AccAddrWidth; core_q_data_op_i in 32; core_q_data_arga_i, core_q_data_argb_i, core_q_data_argc_i in DataWidth each; core_q_rd_i in 5 (destination register).
REQ-006 SHALL have core response ports: core_p_valid_o out 1; core_p_ready_i in 1; core_p_data_o out DataWidth; core_p_rd_o out 5; core_p_error_o out 1 (unknown id).
REQ-007 SHALL have interconnect request ports: acc_q_valid_o out 1; acc_q_ready_i in 1; acc_q_addr_o out AccAddrWidth; acc_q_data_op_o out 32; acc_q_data_arga_o, acc_q_data_argb_o, acc_q_data_argc_o out DataWidth each; acc_q_id_o out 5.
REQ-008 SHALL have interconnect response ports: acc_p_valid_i in 1; acc_p_ready_o out 1; acc_p_data_i in DataWidth; acc_p_id_i in 5 (low 5 bits of returned id).
REQ-009 SHALL have status port outstanding_o out $clog2(NumOutstanding+1), the current in-flight count.

Function
REQ-010 SHALL hold a table of NumOutstanding entries, each a valid bit plus the 5-bit rd.
REQ-011 SHALL select the lowest-index free entry as the allocation index; acc_q_id_o SHALL equal that index zero-extended to 5 bits.
REQ-012 SHALL forward core request payload to the acc_q outputs combinationally; acc_q_valid_o = core_q_valid_i AND a free entry exists.
REQ-013 SHALL drive core_q_ready_o = acc_q_ready_i AND a free entry exists; no payload SHALL pass while the table is full.
REQ-014 SHALL, on acc_q valid&ready, set the allocated entry valid and store core_q_rd_i at the next rising edge.
REQ-015 SHALL compute free-entry availability from registered state only; an entry freed in cycle N is allocatable from cycle N+1 (no bypass).
REQ-016 SHALL, without the spill option, drive core_p_valid_o = acc_p_valid_i, core_p_data_o = acc_p_data_i, acc_p_ready_o = core_p_ready_i.
REQ-017 SHALL drive core_p_rd_o from the entry indexed by acc_p_id_i when that entry is valid and the id < NumOutstanding, with core_p_error_o = 0.
REQ-018 SHALL, for an id >= NumOutstanding or an invalid entry, drive core_p_rd_o = 0, core_p_error_o = 1, and still complete the handshake without changing table state.
REQ-019 SHALL clear the addressed entry's valid bit at the edge ending a response handshake with a known id.
REQ-020 SHALL handle allocation and release in the same cycle independently; allocation and release of the same index in one cycle cannot occur (per REQ-015).
REQ-021 SHALL maintain outstanding_o as allocations minus releases, net change -1, 0 or +1 per cycle, never exceeding NumOutstanding.
REQ-022 SHALL keep acc_q_valid_o asserted with stable payload once raised until acc_q_ready_i, given the core holds its request stable.

Reset
REQ-023 SHALL, while rst_i = 1, asynchronously clear all valid bits and stored rd values to 0 and outstanding_o to 0.
REQ-024 SHALL drop in-flight tracking on reset mid-operation; responses arriving after reset release SHALL be reported with core_p_error_o = 1.
REQ-025 SHALL hold core_p_valid_o = 0 during reset in both configurations; acc_q_valid_o follows REQ-012 with an empty table.

Configuration
REQ-026 SHALL, when macro ACC_OFFLOAD_TRACKER_RSP_SPILL_EN is defined, insert a two-entry spill register between the acc_p and core_p interfaces: one cycle latency, full throughput, acc_p_ready_o decoupled from core_p_ready_i; rd/error lookup and entry release occur at the acc_p handshake.
REQ-027 SHALL, when ACC_OFFLOAD_TRACKER_RSP_SPILL_EN is undefined, use the zero-latency combinational response path of REQ-016.

Verification
REQ-028 Reset, then 4 back-to-back requests rd=1..4 with acc_q_ready_i=1 -> acc_q_id_o 0,1,2,3; outstanding_o=4; core_q_ready_o=0 on the 5th.
REQ-029 Table full, response id=2 data=0xDEADBEEF -> core_p_rd_o=3, error=0; new request accepted the following cycle with acc_q_id_o=2.
REQ-030 Response with id=7 (NumOutstanding=4) -> core_p_error_o=1, core_p_rd_o=0, handshake completes, outstanding_o unchanged.
REQ-031 Same-cycle allocation (id 1) and release (id 0) with 2 outstanding -> outstanding_o stays 2; entry 0 free, entry 1 valid.
REQ-032 core_p_ready_i=0 for 3 cycles with response pending -> data stable, entry not released until ready; with spill macro, core_p_valid_o rises one cycle after acc_p_valid_i.
REQ-033 rst_i asserted with 3 outstanding -> outstanding_o=0 immediately; later response id=1 -> core_p_error_o=1.
